pipeline_ctrl: RTL

Central pipeline sequencing block for the 5-stage MIPS core. It drives the enable and flush (nop) controls of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from memory-hit, hazard, control-flow and halt inputs. It also runs the halt drain sequence and keeps a saturating stall-cycle counter. It sits beside the datapath in the top-level pipeline, outside the stage registers.

---
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the 5-stage MIPS core: stage enables/flushes,
// halt drain FSM and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_jump,
    input  logic             id_halt,
    input  logic             ex_branch_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_nop,
    output logic             idex_nop,
    output logic             exmem_nop,
    output logic             memwb_nop,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_dstall;
    logic               w_lu_hazard;

    assign w_dstall    = (mem_dren | mem_dwen) & ~dhit;
    assign w_lu_hazard = ex_memread & (ex_rt != 5'd0) &
                         ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority in RUN: data stall, taken branch, halt, load-use, jump, fetch miss.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_nop     = 1'b0;
        idex_nop     = 1'b0;
        exmem_nop    = 1'b0;
        memwb_nop    = 1'b0;
        halt         = 1'b0;
        w_next_state = r_state;
        if (!nRST) begin
            w_next_state = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (w_dstall) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_en  = 1'b0;
                        memwb_nop = 1'b1;
                    end else if (ex_branch_taken) begin
                        ifid_nop = 1'b1;
                        idex_nop = 1'b1;
                    end else if (id_halt) begin
                        pc_en        = 1'b0;
                        ifid_nop     = 1'b1;
                        w_next_state = DRAIN;
                    end else if (w_lu_hazard) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_nop = 1'b1;
                    end else if (id_jump) begin
                        ifid_nop = 1'b1;
                    end else if (!ihit) begin
                        pc_en    = 1'b0;
                        ifid_nop = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_en  = 1'b1;
                    ifid_nop = 1'b1;
                    memwb_en = 1'b1;
                    if (w_dstall) begin
                        memwb_nop = 1'b1;
                    end else begin
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                    end
                    if (wb_halt) begin
                        w_next_state = HALTED;
                    end
                end
                HALTED: begin
                    halt = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    // Counts frozen-PC cycles while the core is live; saturates rather than wraps.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if ((r_state != HALTED) && !pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
